// File: rtl/joy_pkg.sv
// Shared constants for the joystick serial chain reader: FSM encoding,
// default port width and button bit positions within a port vector.
package joy_pkg;

  localparam int JOY_BITS_DEFAULT = 12;

  typedef enum logic [1:0] {
    JOY_LOAD   = 2'd0,
    JOY_SAMPLE = 2'd1,
    JOY_SHIFT  = 2'd2,
    JOY_UPDATE = 2'd3
  } joy_state_e;

  // Plain constants so the state register stays a bare logic vector
  localparam logic [1:0] ST_LOAD   = JOY_LOAD;
  localparam logic [1:0] ST_SAMPLE = JOY_SAMPLE;
  localparam logic [1:0] ST_SHIFT  = JOY_SHIFT;
  localparam logic [1:0] ST_UPDATE = JOY_UPDATE;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_FIRE1  = 4;
  localparam int BTN_FIRE2  = 5;
  localparam int BTN_FIRE3  = 6;
  localparam int BTN_FIRE4  = 7;
  localparam int BTN_START  = 8;
  localparam int BTN_SELECT = 9;
  localparam int BTN_MODE   = 10;
  localparam int BTN_AUX    = 11;

  function automatic int joy_frame_ticks(input int joy_bits, input int load_ticks);
    return load_ticks + 4 * joy_bits + 1;
  endfunction

endpackage

// File: rtl/joy_frame_filter.sv
// Debounce stage for the joystick reader: remembers the previous captured frame
// and flags when the new one matches it. Only built when JOY_DEBOUNCE_EN is defined.
`ifdef JOY_DEBOUNCE_EN
module joy_frame_filter #(
  parameter int WIDTH = 24
) (
  input  logic             clk_peripheral,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] frame_in,
  output logic             frame_ok
);

  logic [WIDTH-1:0] prev_frame;

  assign frame_ok = (frame_in == prev_frame);

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      prev_frame <= '0;
    end else if (capture) begin
      prev_frame <= frame_in;
    end
  end

endmodule
`endif

// File: rtl/joy_serial_reader.sv
// Scans a 74HC165-style chain holding both joystick ports, one step per clk_en tick,
// and publishes active-high button vectors. Define JOY_DEBOUNCE_EN for frame debounce.
//
// state  | meaning
// LOAD   | joy_load_n low, chain latching button levels
// SAMPLE | capture current chain bit, raise joy_clk
// SHIFT  | drop joy_clk, advance bit counter or finish frame
// UPDATE | publish captured frame, pulse frame_done, restart load
module joy_serial_reader
  import joy_pkg::*;
#(
  parameter int JOY_BITS   = JOY_BITS_DEFAULT,
  parameter int LOAD_TICKS = 1
) (
  input  logic                clk_peripheral,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                joy_data,
  output logic                joy_load_n,
  output logic                joy_clk,
  output logic [JOY_BITS-1:0] joy_left,
  output logic [JOY_BITS-1:0] joy_right,
  output logic                frame_done
);

  localparam int CHAIN = 2 * JOY_BITS;
  localparam int BW    = $clog2(CHAIN);
  localparam int LW    = (LOAD_TICKS > 1) ? $clog2(LOAD_TICKS + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN - 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_TICKS);
  localparam logic [LW-1:0] LOAD_ONE  = LW'(1);

  logic [1:0]       state;
  logic [BW-1:0]    bit_cnt;
  logic [LW-1:0]    load_cnt;
  logic [CHAIN-1:0] shreg;
  logic             frame_ok;

`ifdef JOY_DEBOUNCE_EN
  joy_frame_filter #(
    .WIDTH (CHAIN)
  ) u_frame_filter (
    .clk_peripheral (clk_peripheral),
    .reset          (reset),
    .capture        (clk_en && (state == ST_UPDATE)),
    .frame_in       (shreg),
    .frame_ok       (frame_ok)
  );
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      state      <= ST_LOAD;
      bit_cnt    <= '0;
      load_cnt   <= '0;
      shreg      <= '0;
      joy_load_n <= 1'b1;
      joy_clk    <= 1'b0;
      joy_left   <= '0;
      joy_right  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clk_en) begin
        case (state)
          ST_LOAD: begin
            joy_clk <= 1'b0;
            if (load_cnt == LOAD_LAST) begin
              joy_load_n <= 1'b1;
              load_cnt   <= '0;
              state      <= ST_SAMPLE;
            end else begin
              joy_load_n <= 1'b0;
              load_cnt   <= load_cnt + LOAD_ONE;
            end
          end
          ST_SAMPLE: begin
            shreg[bit_cnt] <= ~joy_data;
            joy_clk        <= 1'b1;
            state          <= ST_SHIFT;
          end
          ST_SHIFT: begin
            joy_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_UPDATE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_SAMPLE;
            end
          end
          ST_UPDATE: begin
            if (frame_ok) begin
              joy_left   <= shreg[JOY_BITS-1:0];
              joy_right  <= shreg[CHAIN-1:JOY_BITS];
              frame_done <= 1'b1;
            end
            bit_cnt    <= '0;
            // The update tick already drives load low, so it counts as the first load tick
            joy_load_n <= 1'b0;
            load_cnt   <= LOAD_ONE;
            state      <= ST_LOAD;
          end
          default: begin
            state <= ST_LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_reader.sv
// Self-checking bench for joy_serial_reader: behavioural 74HC165 chain plus a
// frame-level scoreboard; honours JOY_DEBOUNCE_EN the same way as the design.
module tb_joy_serial_reader;

  localparam int JB          = 12;
  localparam int CH          = 2 * JB;
  localparam int FRAME_TICKS = 1 + 4 * JB + 1;
`ifdef JOY_DEBOUNCE_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif

  logic          clk_peripheral = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          joy_data;
  logic          joy_load_n;
  logic          joy_clk;
  logic [JB-1:0] joy_left;
  logic [JB-1:0] joy_right;
  logic          frame_done;

  int vectors;
  int miscompares;

  logic [CH-1:0] pressed;
  logic [CH-1:0] chain;
  logic [CH-1:0] cap;
  logic [CH-1:0] prev_frame;
  logic [JB-1:0] exp_left;
  logic [JB-1:0] exp_right;
  logic          exp_pulse;
  logic          glitch;
  logic          glitch_en;
  logic          armed, have_last, prev_ld, prev_jc;
  int frames, pulses, loads, rises, ticks, last_tick, cyc;
  int en_mode;
  int en_div;

  always #5 clk_peripheral = ~clk_peripheral;

  assign joy_data = chain[0] ^ glitch;

  joy_serial_reader dut (
    .clk_peripheral (clk_peripheral),
    .reset          (reset),
    .clk_en         (clk_en),
    .joy_data       (joy_data),
    .joy_load_n     (joy_load_n),
    .joy_clk        (joy_clk),
    .joy_left       (joy_left),
    .joy_right      (joy_right),
    .frame_done     (frame_done)
  );

  // clk_en pattern generator; glitches joy_data only on non-tick cycles
  initial begin
    clk_en = 1'b0;
    glitch = 1'b0;
    en_div = 0;
    forever begin
      @(negedge clk_peripheral);
      case (en_mode)
        1: clk_en = 1'b1;
        2: begin
          en_div = en_div + 1;
          clk_en = ((en_div % 128) == 0);
        end
        3: clk_en = ($urandom_range(0, 2) == 0);
        default: clk_en = 1'b0;
      endcase
      glitch = glitch_en && !clk_en && ($urandom_range(0, 1) == 1);
    end
  end

  // Chain model and frame scoreboard, evaluated just after each clock edge
  task automatic monitor();
    logic completion;
    forever begin
      @(posedge clk_peripheral);
      #1;
      cyc++;
      if (reset) begin
        vectors++;
        if ({joy_load_n, joy_clk, frame_done} !== 3'b100 || joy_left !== '0 || joy_right !== '0) begin
          miscompares++;
          if (miscompares < 50)
            $display("FAIL reset_state got ld=%b clk=%b fd=%b l=%h r=%h expected ld=1 clk=0 fd=0 l=0 r=0",
                     joy_load_n, joy_clk, frame_done, joy_left, joy_right);
        end
        exp_left = '0; exp_right = '0; prev_frame = '0;
        armed = 1'b0; have_last = 1'b0; prev_ld = 1'b1; prev_jc = 1'b0;
        rises = 0; ticks = 0;
      end else begin
        if (clk_en) ticks++;
        if (joy_clk && !prev_jc) rises++;
        completion = prev_ld && !joy_load_n && armed;
        exp_pulse = 1'b0;
        if (completion) begin
          frames++;
          vectors++;
          if (rises !== CH) begin
            miscompares++;
            if (miscompares < 50) $display("FAIL clk_rises got %0d expected %0d", rises, CH);
          end
          if (have_last) begin
            vectors++;
            if (ticks - last_tick !== FRAME_TICKS) begin
              miscompares++;
              if (miscompares < 50) $display("FAIL frame_ticks got %0d expected %0d", ticks - last_tick, FRAME_TICKS);
            end
          end
          last_tick = ticks;
          have_last = 1'b1;
`ifdef JOY_DEBOUNCE_EN
          if (cap == prev_frame) begin
            exp_left = cap[JB-1:0]; exp_right = cap[CH-1:JB]; exp_pulse = 1'b1;
          end
          prev_frame = cap;
`else
          exp_left = cap[JB-1:0]; exp_right = cap[CH-1:JB]; exp_pulse = 1'b1;
`endif
          armed = 1'b0;
        end
        vectors++;
        if (frame_done !== exp_pulse) begin
          miscompares++;
          if (miscompares < 50) $display("FAIL frame_done got %b expected %b at cycle %0d", frame_done, exp_pulse, cyc);
        end
        if (frame_done === 1'b1) pulses++;
        vectors++;
        if (joy_left !== exp_left || joy_right !== exp_right) begin
          miscompares++;
          if (miscompares < 50)
            $display("FAIL buttons got l=%h r=%h expected l=%h r=%h at cycle %0d", joy_left, joy_right, exp_left, exp_right, cyc);
        end
        vectors++;
        if (!joy_load_n && joy_clk) begin
          miscompares++;
          if (miscompares < 50) $display("FAIL load_clk_overlap got ld=0 clk=1 expected never both at cycle %0d", cyc);
        end
        if (!joy_load_n) begin
          chain = ~pressed;
          cap = pressed;
        end else if (joy_clk && !prev_jc) begin
          chain = {1'b1, chain[CH-1:1]};
        end
        if (!prev_ld && joy_load_n) begin
          armed = 1'b1;
          rises = 0;
          loads++;
        end
        prev_ld = joy_load_n;
        prev_jc = joy_clk;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = frames + n;
    for (int i = 0; i < budget && frames < target; i++) @(negedge clk_peripheral);
    if (frames < target) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout got %0d frames expected %0d", frames, target);
    end
  endtask

  task automatic wait_loads(input int n);
    int target;
    target = loads + n;
    for (int i = 0; i < 2000 * n && loads < target; i++) @(negedge clk_peripheral);
    if (loads < target) begin
      vectors++; miscompares++;
      $display("FAIL load_timeout got %0d loads expected %0d", loads, target);
    end
  endtask

  task automatic test_reset();
    en_mode = 1;
    @(negedge clk_peripheral) reset = 1'b1;
    repeat (3) @(negedge clk_peripheral);
    vectors++;
    if ({joy_load_n, joy_clk, frame_done} !== 3'b100 || joy_left !== '0 || joy_right !== '0) begin
      miscompares++;
      $display("FAIL reset_held got ld=%b clk=%b fd=%b expected ld=1 clk=0 fd=0", joy_load_n, joy_clk, frame_done);
    end
    reset = 1'b0;
    @(posedge clk_peripheral);
    #1;
    vectors++;
    if (joy_load_n !== 1'b0) begin
      miscompares++;
      $display("FAIL first_tick_load got %b expected 0", joy_load_n);
    end
    @(negedge clk_peripheral);
  endtask

  task automatic test_single_frame();
    int p0;
    en_mode = 0;
    pressed = 24'h800005;
    @(negedge clk_peripheral) reset = 1'b1;
    @(negedge clk_peripheral) reset = 1'b0;
    p0 = pulses;
    en_mode = 2;
    wait_frames(NEED, 20000);
    vectors++;
    if (joy_left !== 12'h005 || joy_right !== 12'h800) begin
      miscompares++;
      $display("FAIL slow_frame got l=%h r=%h expected l=005 r=800", joy_left, joy_right);
    end
    vectors++;
    if (pulses - p0 !== 1) begin
      miscompares++;
      $display("FAIL slow_pulses got %0d expected 1", pulses - p0);
    end
  endtask

  task automatic test_tied_high();
    int c0;
    en_mode = 1;
    pressed = 24'($urandom());
    wait_frames(1, 200);
    c0 = cyc;
    wait_frames(1, 200);
    vectors++;
    if (cyc - c0 !== FRAME_TICKS) begin
      miscompares++;
      $display("FAIL tied_period got %0d expected %0d", cyc - c0, FRAME_TICKS);
    end
    wait_frames(2, 300);
  endtask

  task automatic test_midframe_reset();
    en_mode = 1;
    pressed = 24'h5A5A5A;
    wait_frames(NEED + 1, 400);
    vectors++;
    if (joy_left !== 12'hA5A || joy_right !== 12'h5A5) begin
      miscompares++;
      $display("FAIL pre_reset got l=%h r=%h expected l=a5a r=5a5", joy_left, joy_right);
    end
    wait_loads(1);
    for (int i = 0; i < 100 && rises < 10; i++) @(negedge clk_peripheral);
    reset = 1'b1;
    pressed = 24'h00F00F;
    @(negedge clk_peripheral);
    vectors++;
    if (joy_left !== '0 || joy_right !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset got l=%h r=%h expected 0", joy_left, joy_right);
    end
    reset = 1'b0;
    wait_frames(NEED, 400);
    vectors++;
    if (joy_left !== 12'h00F || joy_right !== 12'h00F) begin
      miscompares++;
      $display("FAIL post_reset got l=%h r=%h expected l=00f r=00f", joy_left, joy_right);
    end
  endtask

  task automatic test_debounce();
    int p0;
    logic [JB-1:0] hold_l;
    en_mode = 1;
    wait_loads(1);
    pressed = 24'h123456;
    wait_loads(1);
    pressed = 24'h000001;
    wait_loads(1);
    p0 = pulses;
    hold_l = exp_left;
    for (int i = 0; i < 6; i++) begin
      pressed = (i % 2 == 0) ? 24'h000000 : 24'h000001;
      wait_loads(1);
    end
    wait_loads(1);
    vectors++;
`ifdef JOY_DEBOUNCE_EN
    if (pulses - p0 !== 0 || joy_left !== hold_l) begin
      miscompares++;
      $display("FAIL bounce_hold got pulses=%0d l=%h expected pulses=0 l=%h", pulses - p0, joy_left, hold_l);
    end
`else
    if (pulses - p0 !== 7 || joy_left !== 12'h001) begin
      miscompares++;
      $display("FAIL bounce_pass got pulses=%0d l=%h expected pulses=7 l=001", pulses - p0, joy_left);
    end
`endif
    wait_frames(1, 200);
    vectors++;
`ifdef JOY_DEBOUNCE_EN
    if (pulses - p0 !== 1 || joy_left !== 12'h001 || joy_right !== '0) begin
      miscompares++;
      $display("FAIL stable_accept got pulses=%0d l=%h r=%h expected pulses=1 l=001 r=000", pulses - p0, joy_left, joy_right);
    end
`else
    if (pulses - p0 !== 8 || joy_left !== 12'h001 || joy_right !== '0) begin
      miscompares++;
      $display("FAIL stable_accept got pulses=%0d l=%h r=%h expected pulses=8 l=001 r=000", pulses - p0, joy_left, joy_right);
    end
`endif
  endtask

  task automatic test_random_glitch();
    logic [CH-1:0] last;
    en_mode = 3;
    glitch_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pressed = 24'($urandom());
      wait_loads(1);
    end
    last = 24'($urandom());
    pressed = last;
    wait_frames(NEED + 1, 3000);
    vectors++;
    if (joy_left !== last[JB-1:0] || joy_right !== last[CH-1:JB]) begin
      miscompares++;
      $display("FAIL random_final got l=%h r=%h expected l=%h r=%h", joy_left, joy_right, last[JB-1:0], last[CH-1:JB]);
    end
    glitch_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pressed = '0;
    chain = '1;
    cap = '0;
    prev_frame = '0;
    exp_left = '0;
    exp_right = '0;
    exp_pulse = 1'b0;
    glitch_en = 1'b0;
    armed = 1'b0; have_last = 1'b0; prev_ld = 1'b1; prev_jc = 1'b0;
    frames = 0; pulses = 0; loads = 0; rises = 0; ticks = 0; last_tick = 0; cyc = 0;
    en_mode = 0;
    vectors = 0;
    miscompares = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_tied_high();
    test_midframe_reset();
    test_debounce();
    test_random_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
